// File: rtl/vad_pkg.sv
// Shared defaults and state encodings for the MFCC feature framer.
package vad_pkg;

  localparam int N_MFCC = 13;
  localparam int FEAT_W = 32;

  typedef enum logic [1:0] {
    W_FILL   = 2'd0,
    W_DROP   = 2'd1,
    W_RESYNC = 2'd2
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE   = 2'd0,
    R_STREAM = 2'd1,
    R_GAP    = 2'd2
  } rd_state_t;

  // Index width for a counter covering 0..n-1, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/feat_bank_ram.sv
// Two-bank coefficient store: one write port, one registered read port.
// Address is {bank, index}; depth is rounded up to a power of two so the
// concatenated address can never point outside the array.
module feat_bank_ram #(
  parameter int DATA_W = 32,
  parameter int AW     = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**AW];

  // Synchronous write, no reset on the array so it maps to distributed RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read; the output register holds its value between bursts.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/mfcc_feat_framer.sv
// MFCC feature framer: collects one frame of coefficients into a ping-pong
// buffer and replays it as a single contiguous burst with no back-pressure.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// W_FILL   | writing coefficients of the current frame into bank wb
// W_DROP   | both banks full at frame start; swallowing the whole frame
// W_RESYNC | frame ran past N_FEAT without last; waiting for coef_last
// R_IDLE   | waiting for bank rb to become full
// R_STREAM | reading bank rb, one word per cycle
// R_GAP    | enforcing idle cycles between output frames
module mfcc_feat_framer
  import vad_pkg::*;
#(
  parameter int N_FEAT = N_MFCC,
  parameter int DATA_W = FEAT_W,
  parameter int GAP    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              coef_valid,
  input  logic [DATA_W-1:0] coef_data,
  input  logic              coef_last,
  output logic              tvalid_mfcc_feat,
  output logic [DATA_W-1:0] mfcc_feat,
  output logic              tlast_mfcc_feat,
  output logic              overflow,
  output logic              len_err,
  output logic              busy
);

  localparam int             IW       = idx_width(N_FEAT);
  localparam int             GW       = $clog2(GAP + 2);
  localparam logic [IW-1:0]  LAST_IDX = IW'(N_FEAT - 1);
  localparam logic [GW-1:0]  GAP_LOAD = GW'((GAP > 0) ? (GAP - 1) : 0);

  wr_state_t      w_state;
  logic [IW-1:0]  widx;
  logic           wb;

  rd_state_t      r_state;
  logic [IW-1:0]  ridx;
  logic           rb;
  logic [GW-1:0]  gap_cnt;

  logic [1:0]     full;

  logic           wr_fire;
  logic           wr_done;
  logic           rd_fire;
  logic           rd_done;

  // The write is gated by full[wb] only at idx 0; once a frame is accepted
  // its bank cannot become full underneath it, since only the writer sets it.
  assign wr_fire = coef_valid && (w_state == W_FILL) && !((widx == '0) && full[wb]);
  assign wr_done = wr_fire && coef_last && (widx == LAST_IDX);
  assign rd_fire = (r_state == R_STREAM);
  assign rd_done = rd_fire && (ridx == LAST_IDX);

  assign busy = (|full) || (r_state == R_STREAM) || tvalid_mfcc_feat;

  // Bank-full flags: writer sets, reader clears; they always hit different banks.
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= '0;
    end else begin
      full[0] <= (full[0] && !(rd_done && !rb)) || (wr_done && !wb);
      full[1] <= (full[1] && !(rd_done &&  rb)) || (wr_done &&  wb);
    end
  end

  // Write-side FSM: frame assembly, length checking and overflow dropping.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state  <= W_FILL;
      widx     <= '0;
      wb       <= 1'b0;
      overflow <= 1'b0;
      len_err  <= 1'b0;
    end else begin
      overflow <= 1'b0;
      len_err  <= 1'b0;
      case (w_state)
        W_FILL: begin
          if (coef_valid) begin
            if ((widx == '0) && full[wb]) begin
              // A one-word frame into a full buffer is still an overflow, not a length error.
              if (coef_last) begin
                overflow <= 1'b1;
              end else begin
                widx    <= IW'(1);
                w_state <= W_DROP;
              end
            end else if (coef_last) begin
              widx <= '0;
              if (widx == LAST_IDX) begin
                wb <= ~wb;
              end else begin
                len_err <= 1'b1;
              end
            end else if (widx == LAST_IDX) begin
              len_err <= 1'b1;
              widx    <= '0;
              w_state <= W_RESYNC;
            end else begin
              widx <= widx + 1'b1;
            end
          end
        end
        W_DROP: begin
          if (coef_valid) begin
            if (coef_last || (widx == LAST_IDX)) begin
              overflow <= 1'b1;
              widx     <= '0;
              w_state  <= W_FILL;
            end else begin
              widx <= widx + 1'b1;
            end
          end
        end
        W_RESYNC: begin
          if (coef_valid && coef_last) begin
            widx    <= '0;
            w_state <= W_FILL;
          end
        end
        default: begin
          widx    <= '0;
          w_state <= W_FILL;
        end
      endcase
    end
  end

  // Read-side FSM: burst replay, inter-frame gap, and aligned valid/last.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= R_IDLE;
      ridx             <= '0;
      rb               <= 1'b0;
      gap_cnt          <= '0;
      tvalid_mfcc_feat <= 1'b0;
      tlast_mfcc_feat  <= 1'b0;
    end else begin
      // Valid/last trail the read enable by one cycle to line up with rdata.
      tvalid_mfcc_feat <= rd_fire;
      tlast_mfcc_feat  <= rd_done;
      case (r_state)
        R_IDLE: begin
          if (full[rb]) begin
            ridx    <= '0;
            r_state <= R_STREAM;
          end
        end
        R_STREAM: begin
          if (ridx == LAST_IDX) begin
            ridx <= '0;
            rb   <= ~rb;
            if (GAP > 0) begin
              gap_cnt <= GAP_LOAD;
              r_state <= R_GAP;
            end else if (full[rb ^ 1'b1]) begin
              r_state <= R_STREAM;
            end else begin
              r_state <= R_IDLE;
            end
          end else begin
            ridx <= ridx + 1'b1;
          end
        end
        R_GAP: begin
          if (gap_cnt == '0) begin
            r_state <= R_IDLE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= R_IDLE;
        end
      endcase
    end
  end

  feat_bank_ram #(
    .DATA_W (DATA_W),
    .AW     (IW + 1)
  ) u_bank_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_fire),
    .waddr ({wb, widx}),
    .wdata (coef_data),
    .re    (rd_fire),
    .raddr ({rb, ridx}),
    .rdata (mfcc_feat)
  );

endmodule

// File: doc/mfcc_feat_framer.md
Name: mfcc_feat_framer

Overview:
- Producer end of the MFCC-feature stream consumed by the SVM pipeline (`tvalid_mfcc_feat` / `mfcc_feat`).
- Accepts one frame of N_FEAT coefficients from the MFCC/DCT stage, with per-coefficient valid and last markers.
- Buffers each frame in a ping-pong buffer and re-emits it as one contiguous burst of N_FEAT words, one word per clock. The consumer has no back-pressure, so a frame is never split.
- Detects frame-length errors and overflow. Bad frames are dropped whole; they are never streamed partially.

Parameters:
- N_FEAT, 13, coefficients per frame (≥2).
- DATA_W, 32, coefficient width.
- GAP, 0, minimum idle cycles between output frames (0 = back-to-back allowed).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- coef_valid  in  1  input coefficient strobe.
- coef_data  in  DATA_W  input coefficient.
- coef_last  in  1  marks the final coefficient of a frame; sampled only when coef_valid=1.
- tvalid_mfcc_feat  out  1  output word valid.
- mfcc_feat  out  DATA_W  output coefficient.
- tlast_mfcc_feat  out  1  high with the N_FEAT-th output word.
- overflow  out  1  one-cycle pulse: a frame was dropped because both banks were full.
- len_err  out  1  one-cycle pulse: a frame was dropped because of a length mismatch.
- busy  out  1  high when any bank is full or the output is streaming.

Behaviour:
- Reset (clk edge with rst=1):
  - All outputs become 0 from the next cycle.
  - Both bank-full flags, the write/read bank pointers (both → 0), the index counters and the FSMs are cleared.
  - A partially received or partially streamed frame is abandoned.
- Write side (states W_FILL, W_DROP, W_RESYNC):
  - W_FILL, first coefficient of a frame (idx=0):
    - if full[wb]=1, go to W_DROP and flag the frame for an overflow pulse;
    - otherwise write bank wb at idx.
  - Each accepted coefficient increments idx.
  - coef_last with idx=N_FEAT-1: set full[wb], toggle wb, idx←0.
  - coef_last with idx<N_FEAT-1: discard the bank (full stays 0), pulse len_err, idx←0.
  - idx=N_FEAT-1 without coef_last: pulse len_err, go to W_RESYNC.
  - W_RESYNC: ignore coefficients until coef_last, then idx←0 and return to W_FILL.
  - W_DROP: ignore coefficients until coef_last or the N_FEAT-th coefficient, pulse overflow at the end, return to W_FILL.
    - Stays dropping even if full[wb] clears mid-frame.
    - A length mismatch inside a dropped frame reports overflow only.
- Read side (states R_IDLE, R_STREAM, R_GAP):
  - R_IDLE: if full[rb], go to R_STREAM with ridx=0.
  - R_STREAM: read bank rb at ridx every cycle; ridx increments.
  - At ridx=N_FEAT-1:
    - clear full[rb] and toggle rb;
    - go to R_GAP if GAP>0;
    - else go straight to R_STREAM if full of the next bank is already set, otherwise R_IDLE.
  - R_GAP: count GAP cycles, then R_IDLE.
- Output timing:
  - The RAM read is registered; tvalid_mfcc_feat and tlast_mfcc_feat are delayed one cycle to align with the data.
  - mfcc_feat holds its last value when tvalid=0.
- Latency: the last coefficient is sampled at edge E0 → first output word is valid after edge E2 (2 cycles). Output words are contiguous for N_FEAT cycles.
- Simultaneous events:
  - Writer setting full[wb] and reader clearing full[rb] in the same cycle always touch different banks; both take effect.
  - Writer completing into bank X while the reader starts bank X is impossible, because full[X] gates the write.
- Data pass-through is bit-exact; no arithmetic.
- The input has no ready signal. The MFCC stage rate-limits so that in normal operation each frame's N_FEAT cycles plus GAP are shorter than its frame period; overflow is the diagnostic when that does not hold.

Decomposition:
- vad_pkg holds:
  - localparams N_MFCC=13 and FEAT_W=32, used as the defaults;
  - write-FSM and read-FSM state enums.
- Sub-module feat_bank_ram: simple dual-port, 2·N_FEAT × DATA_W.
  - Synchronous write.
  - Registered read.
  - Address = {bank, idx}.
  - Maps to distributed RAM.

Test Plan:
- Single frame: 13 coefficients 0x100..0x10C with last on the 13th → 2 cycles later 13 consecutive valid words 0x100..0x10C, tlast on 0x10C, no error pulses.
- Back-to-back: two frames fed with no input gap, GAP=0 → 26 contiguous output words in order; busy falls after the last word.
- Overflow: three frames fed while the output is stalled by GAP=40 → frames 1 and 2 are streamed, frame 3 is dropped with one overflow pulse, and no partial words appear.
- Short frame: coef_last on the 5th coefficient → len_err pulse, no output; the next good frame streams correctly.
- Long frame: 15 coefficients with last on the 15th → len_err pulse at the 13th, no output; the following frame is accepted.
- Reset mid-stream: assert rst for 1 cycle at output word 6 → tvalid=0 the next cycle and stays 0; a frame fed afterwards streams in full from word 0.
